mips_control_unit: RTL and testbench
====================================

Name: mips_control_unit

Overview:
- Multi-cycle Moore control unit that drives the integer datapath's control word (S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, HILO_ld, Y_Sel) plus PC, IR and memory strobes.
- Sequences each instruction through FETCH, DECODE, EXEC, optional MEM, and WB or BR.
- Decodes a fixed MIPS subset from the IR word and the registered ALU status flags.
- Sits beside the datapath in the CPU top, as the initiator of that datapath's control interface.

Parameters:
- RESET_PC_SEL, 2'b11: pc_sel value asserted with pc_ld in RESET state (loads reset vector).
- ENABLE_HALT, 1: when 1, illegal opcodes and break enter HALT; when 0 they are executed as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state RESET.
- IR  in  32  current instruction word from datapath IR register.
- C, V, N, Z  in  1 each  ALU status from datapath.
- pc_ld  out  1  load PC from source selected by pc_sel.
- pc_inc  out  1  PC <= PC+4.
- pc_sel  out  2  0 = branch target, 1 = jump target, 2 = register (jr), 3 = reset vector.
- ir_ld  out  1  load IR from instruction memory.
- im_cs, im_rd  out  1 each  instruction memory strobes.
- dm_cs, dm_rd, dm_wr  out  1 each  data memory strobes.
- S_Addr, T_Addr, D_Addr  out  5 each  register file addresses.
- D_En  out  1  register file write enable.
- FS  out  5  ALU function select.
- T_Sel  out  1  0 = register T, 1 = immediate DT.
- HILO_ld  out  1  HI/LO load.
- Y_Sel  out  3  0 = PC, 1 = DY (memory), 2 = ALU lo, 3 = LO, 4 = HI.
- halt  out  1  high in HALT state.

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, BR, HALT. Encoded as a 3-bit state register updated on posedge clk and cleared asynchronously by reset.
- Outputs are combinational from state and IR. Any output not named for a state is 0.
- S_Addr = IR[25:21] and T_Addr = IR[20:16] in every state.
- RESET: pc_ld=1, pc_sel=RESET_PC_SEL. Next state is FETCH.
- FETCH: im_cs=im_rd=ir_ld=pc_inc=1. Next state is DECODE.
- DECODE: no strobes.
  - Illegal opcode or funct: next state is HALT (ENABLE_HALT=1) or FETCH (ENABLE_HALT=0).
  - j: pc_ld=1, pc_sel=1, next FETCH.
  - jr: pc_ld=1, pc_sel=2, next FETCH.
  - Otherwise next state is EXEC.
- EXEC: FS per decode table.
  - T_Sel=1 for I-type, 0 for R-type.
  - mult/div: HILO_ld=1, next FETCH.
  - lw/sw: FS=ADD with T_Sel=1, next MEM.
  - beq/bne: FS=SUB with T_Sel=0. Z is captured into internal register zf at the clock edge leaving EXEC. Next BR.
  - All others: next WB.
- MEM: dm_cs=1.
  - lw: dm_rd=1, next WB.
  - sw: dm_wr=1, next FETCH.
- WB: D_En=1.
  - D_Addr = IR[15:11] for R-type, IR[20:16] for I-type.
  - Y_Sel: 1 for lw, 3 for mflo, 4 for mfhi, else 2.
  - FS is held at its EXEC value. Next FETCH.
- BR: pc_ld=1, pc_sel=0 when (beq and zf) or (bne and !zf). Next FETCH.
- HALT: halt=1; remains until reset.
- A write with D_Addr=0 is still issued; the register file ignores it.
- Reset mid-instruction abandons the instruction with no memory or register write. The first cycle after reset deasserts is RESET.
- C, V, N are inputs only; no trap on overflow in this revision.
- Latencies: ALU and immediate ops 4 cycles, lw 5, sw 4, mult/div 3, branch 4, j/jr 2.

Decomposition:
- Package mips_pkg:
  - opcode constants: RTYPE=6'h00, J=6'h02, BEQ=6'h04, BNE=6'h05, ADDI=6'h08, ORI=6'h0D, LUI=6'h0F, LW=6'h23, SW=6'h2B.
  - funct constants: ADD=6'h20, ADDU=6'h21, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SLT=6'h2A, MULT=6'h18, DIV=6'h1A, MFHI=6'h10, MFLO=6'h12, JR=6'h08, BREAK=6'h0D.
  - FS codes: PASS_S=5'h00, ADD=5'h02, ADDU=5'h03, SUB=5'h04, SLT=5'h06, AND=5'h08, OR=5'h09, XOR=5'h0A, LUI=5'h0D, MUL=5'h1E, DIV=5'h1F.
  - State encoding.
- One sub-module: mips_decode. It is purely combinational and maps IR to {fs, is_itype, class, legal}. The FSM stays in mips_control_unit.

Test Plan:
- Reset pulse, then release -> cycle 1: pc_ld=1, pc_sel=3; cycle 2: ir_ld=im_rd=pc_inc=1; all other outputs 0 throughout.
- IR=0x014B4820 (add $9,$10,$11) -> EXEC: FS=5'h02, T_Sel=0; WB: D_En=1, D_Addr=9, Y_Sel=2; FETCH follows.
- IR=0x8D280004 (lw $8,4($9)) -> EXEC: FS=ADD, T_Sel=1; MEM: dm_cs=dm_rd=1; WB: D_Addr=8, Y_Sel=1.
- IR=0x11090003 (beq) with Z=1 in EXEC -> BR: pc_ld=1, pc_sel=0. With Z=0 -> pc_ld=0.
- IR=0x012A0018 (mult) -> EXEC: HILO_ld=1, FS=5'h1E, no WB. Then IR=0x00006012 (mflo $12) -> WB: Y_Sel=3, D_Addr=12.
- IR=0xFC000000 (illegal) -> HALT with halt=1 held for 10 cycles. Reset asserted in MEM of sw -> dm_wr never pulses and state returns to RESET.

Source files
------------

// File: rtl/mips_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the multi-cycle MIPS control unit: opcode and
//   funct field values, ALU function-select codes, PC / Y-mux select codes,
//   the FSM state encoding and the instruction class produced by the decoder.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Primary opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field IR[5:0]
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  // ALU function select
  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_ADDU   = 5'h03;
  localparam logic [4:0] FS_SUB    = 5'h04;
  localparam logic [4:0] FS_SLT    = 5'h06;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_LUI    = 5'h0D;
  localparam logic [4:0] FS_MUL    = 5'h1E;
  localparam logic [4:0] FS_DIV    = 5'h1F;

  // PC source select
  localparam logic [1:0] PCS_BRANCH = 2'd0;
  localparam logic [1:0] PCS_JUMP   = 2'd1;
  localparam logic [1:0] PCS_REG    = 2'd2;

  // Register-file write-back mux select
  localparam logic [2:0] YS_PC  = 3'd0;
  localparam logic [2:0] YS_DY  = 3'd1;
  localparam logic [2:0] YS_ALU = 3'd2;
  localparam logic [2:0] YS_LO  = 3'd3;
  localparam logic [2:0] YS_HI  = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BR     = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // What the sequencer needs to know about an instruction beyond its FS code.
  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_JR,
    CL_MULDIV,
    CL_MFHI,
    CL_MFLO,
    CL_BREAK
  } instr_class_e;

  function automatic logic is_branch(instr_class_e cls);
    return (cls == CL_BEQ) || (cls == CL_BNE);
  endfunction

endpackage

// File: rtl/mips_control_unit_if.sv
// ---------------------------------------------------------------------------
// mips_control_unit_if
//   Control interface between the control unit (master) and the integer
//   datapath (slave). The datapath supplies the IR word and ALU status; the
//   control unit returns the full control word plus PC, IR and memory strobes.
//   Signals:
//     IR, C, V, N, Z               datapath -> control
//     pc_ld, pc_inc, pc_sel        PC control
//     ir_ld, im_cs, im_rd          instruction fetch
//     dm_cs, dm_rd, dm_wr          data memory strobes
//     S_Addr, T_Addr, D_Addr, D_En register file
//     FS, T_Sel, HILO_ld, Y_Sel    ALU / write-back control
//     halt                         control unit halted
// ---------------------------------------------------------------------------
interface mips_control_unit_if;
  logic [31:0] IR;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;

  logic        pc_ld;
  logic        pc_inc;
  logic [1:0]  pc_sel;
  logic        ir_ld;
  logic        im_cs;
  logic        im_rd;
  logic        dm_cs;
  logic        dm_rd;
  logic        dm_wr;
  logic [4:0]  S_Addr;
  logic [4:0]  T_Addr;
  logic [4:0]  D_Addr;
  logic        D_En;
  logic [4:0]  FS;
  logic        T_Sel;
  logic        HILO_ld;
  logic [2:0]  Y_Sel;
  logic        halt;

  modport master (
    input  IR, C, V, N, Z,
    output pc_ld, pc_inc, pc_sel, ir_ld, im_cs, im_rd,
           dm_cs, dm_rd, dm_wr, S_Addr, T_Addr, D_Addr, D_En,
           FS, T_Sel, HILO_ld, Y_Sel, halt
  );

  modport slave (
    output IR, C, V, N, Z,
    input  pc_ld, pc_inc, pc_sel, ir_ld, im_cs, im_rd,
           dm_cs, dm_rd, dm_wr, S_Addr, T_Addr, D_Addr, D_En,
           FS, T_Sel, HILO_ld, Y_Sel, halt
  );
endinterface

// File: rtl/mips_control_unit_decode.sv
// ---------------------------------------------------------------------------
// mips_decode
//   Purely combinational instruction decoder.
//   Ports:
//     opcode_i    IR[31:26]
//     funct_i     IR[5:0]
//     fs_o        ALU function select for this instruction
//     is_itype_o  1 for any non-R-type opcode
//     cls_o       instruction class used by the sequencer
//     legal_o     0 for opcodes / functs outside the supported subset
// ---------------------------------------------------------------------------
module mips_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output logic [4:0]   fs_o,
  output logic         is_itype_o,
  output instr_class_e cls_o,
  output logic         legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    fs_o       = FS_PASS_S;
    is_itype_o = (opcode_i != OP_RTYPE);
    cls_o      = CL_NOP;
    legal_o    = 1'b1;

    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:   begin fs_o = FS_ADD;  cls_o = CL_ALU_R;  end
          FN_ADDU:  begin fs_o = FS_ADDU; cls_o = CL_ALU_R;  end
          FN_SUB:   begin fs_o = FS_SUB;  cls_o = CL_ALU_R;  end
          FN_AND:   begin fs_o = FS_AND;  cls_o = CL_ALU_R;  end
          FN_OR:    begin fs_o = FS_OR;   cls_o = CL_ALU_R;  end
          FN_XOR:   begin fs_o = FS_XOR;  cls_o = CL_ALU_R;  end
          FN_SLT:   begin fs_o = FS_SLT;  cls_o = CL_ALU_R;  end
          FN_MULT:  begin fs_o = FS_MUL;  cls_o = CL_MULDIV; end
          FN_DIV:   begin fs_o = FS_DIV;  cls_o = CL_MULDIV; end
          FN_MFHI:  cls_o = CL_MFHI;
          FN_MFLO:  cls_o = CL_MFLO;
          FN_JR:    cls_o = CL_JR;
          FN_BREAK: cls_o = CL_BREAK;
          default:  legal_o = 1'b0;
        endcase
      end
      OP_J:    cls_o = CL_J;
      OP_BEQ:  begin fs_o = FS_SUB; cls_o = CL_BEQ;   end
      OP_BNE:  begin fs_o = FS_SUB; cls_o = CL_BNE;   end
      OP_ADDI: begin fs_o = FS_ADD; cls_o = CL_ALU_I; end
      OP_ORI:  begin fs_o = FS_OR;  cls_o = CL_ALU_I; end
      OP_LUI:  begin fs_o = FS_LUI; cls_o = CL_ALU_I; end
      // Loads and stores use the ALU for base + offset.
      OP_LW:   begin fs_o = FS_ADD; cls_o = CL_LW;    end
      OP_SW:   begin fs_o = FS_ADD; cls_o = CL_SW;    end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// ---------------------------------------------------------------------------
// mips_control_unit
//   Multi-cycle Moore control unit for the integer datapath. Each instruction
//   walks FETCH -> DECODE -> EXEC -> [MEM] -> WB / BR; j and jr retire from
//   DECODE, mult/div from EXEC. Outputs are decoded from the state register
//   and the current IR word.
//   Parameters:
//     RESET_PC_SEL  pc_sel value driven with pc_ld in RESET
//     ENABLE_HALT   1: illegal / break enter HALT, 0: treated as NOP
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     ctrl   datapath control interface (master side)
// ---------------------------------------------------------------------------
module mips_control_unit
  import mips_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'b11,
  parameter bit         ENABLE_HALT  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  mips_control_unit_if.master ctrl
);

  state_e       state_q;
  logic         zf_q;

  logic [4:0]   dec_fs;
  logic         dec_itype;
  instr_class_e dec_cls;
  logic         dec_legal;
  logic         trap;

  mips_decode u_decode (
    .opcode_i   (ctrl.IR[31:26]),
    .funct_i    (ctrl.IR[5:0]),
    .fs_o       (dec_fs),
    .is_itype_o (dec_itype),
    .cls_o      (dec_cls),
    .legal_o    (dec_legal)
  );

  // break shares the illegal-instruction path.
  assign trap = !dec_legal || (dec_cls == CL_BREAK);

  // -------------------------------------------------------------------------
  // Sequencer. zf_q holds the branch compare result across the EXEC->BR edge
  // so BR does not depend on the datapath keeping Z stable.
  // -------------------------------------------------------------------------
  // NOTE: reset is in the sensitivity list, so it takes effect immediately
  // and abandons whatever instruction was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      zf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state_q)
        ST_RESET:  state_q <= ST_FETCH;
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: begin
          if (trap)
            state_q <= ENABLE_HALT ? ST_HALT : ST_FETCH;
          else if ((dec_cls == CL_J) || (dec_cls == CL_JR))
            state_q <= ST_FETCH;
          else
            state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (dec_cls)
            CL_MULDIV:   state_q <= ST_FETCH;
            CL_LW, CL_SW: state_q <= ST_MEM;
            CL_BEQ, CL_BNE: begin
              zf_q    <= ctrl.Z;
              state_q <= ST_BR;
            end
            default:     state_q <= ST_WB;
          endcase
        end
        ST_MEM:    state_q <= (dec_cls == CL_LW) ? ST_WB : ST_FETCH;
        ST_WB:     state_q <= ST_FETCH;
        ST_BR:     state_q <= ST_FETCH;
        ST_HALT:   state_q <= ST_HALT;
        default:   state_q <= ST_RESET;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control word
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl.pc_ld   = 1'b0;
    ctrl.pc_inc  = 1'b0;
    ctrl.pc_sel  = PCS_BRANCH;
    ctrl.ir_ld   = 1'b0;
    ctrl.im_cs   = 1'b0;
    ctrl.im_rd   = 1'b0;
    ctrl.dm_cs   = 1'b0;
    ctrl.dm_rd   = 1'b0;
    ctrl.dm_wr   = 1'b0;
    ctrl.S_Addr  = ctrl.IR[25:21];
    ctrl.T_Addr  = ctrl.IR[20:16];
    ctrl.D_Addr  = 5'd0;
    ctrl.D_En    = 1'b0;
    ctrl.FS      = FS_PASS_S;
    ctrl.T_Sel   = 1'b0;
    ctrl.HILO_ld = 1'b0;
    ctrl.Y_Sel   = YS_PC;
    ctrl.halt    = 1'b0;

    case (state_q)
      ST_RESET: begin
        ctrl.pc_ld  = 1'b1;
        ctrl.pc_sel = RESET_PC_SEL;
      end
      ST_FETCH: begin
        ctrl.im_cs  = 1'b1;
        ctrl.im_rd  = 1'b1;
        ctrl.ir_ld  = 1'b1;
        ctrl.pc_inc = 1'b1;
      end
      ST_DECODE: begin
        if (!trap && (dec_cls == CL_J)) begin
          ctrl.pc_ld  = 1'b1;
          ctrl.pc_sel = PCS_JUMP;
        end else if (!trap && (dec_cls == CL_JR)) begin
          ctrl.pc_ld  = 1'b1;
          ctrl.pc_sel = PCS_REG;
        end
      end
      ST_EXEC: begin
        ctrl.FS      = dec_fs;
        // Branches compare two registers even though they are I-type.
        ctrl.T_Sel   = dec_itype && !is_branch(dec_cls);
        ctrl.HILO_ld = (dec_cls == CL_MULDIV);
      end
      ST_MEM: begin
        ctrl.dm_cs = 1'b1;
        ctrl.dm_rd = (dec_cls == CL_LW);
        ctrl.dm_wr = (dec_cls == CL_SW);
      end
      ST_WB: begin
        ctrl.D_En   = 1'b1;
        ctrl.D_Addr = dec_itype ? ctrl.IR[20:16] : ctrl.IR[15:11];
        ctrl.FS     = dec_fs;
        case (dec_cls)
          CL_LW:   ctrl.Y_Sel = YS_DY;
          CL_MFLO: ctrl.Y_Sel = YS_LO;
          CL_MFHI: ctrl.Y_Sel = YS_HI;
          default: ctrl.Y_Sel = YS_ALU;
        endcase
      end
      ST_BR: begin
        if (((dec_cls == CL_BEQ) && zf_q) || ((dec_cls == CL_BNE) && !zf_q))
          ctrl.pc_ld = 1'b1;
      end
      ST_HALT:  ctrl.halt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_control_unit
//   Expected control words are queued per cycle as each instruction is
//   scheduled, then popped and compared against the DUT on every falling
//   edge. The IR/Z inputs are updated right after the FETCH compare, as the
//   datapath's IR register would be loaded at the end of FETCH.
// ---------------------------------------------------------------------------
module tb_mips_control_unit;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       im_cs;
    logic       im_rd;
    logic       dm_cs;
    logic       dm_rd;
    logic       dm_wr;
    logic [4:0] s_addr;
    logic [4:0] t_addr;
    logic [4:0] d_addr;
    logic       d_en;
    logic [4:0] fs;
    logic       t_sel;
    logic       hilo_ld;
    logic [2:0] y_sel;
    logic       halt;
  } ctrl_vec_t;

  typedef struct {
    ctrl_vec_t   vec;
    bit          load;
    logic [31:0] nir;
    logic        nz;
  } exp_t;

  logic clk;
  logic reset;

  mips_control_unit_if ctrl_if ();

  mips_control_unit #(
    .RESET_PC_SEL (2'b11),
    .ENABLE_HALT  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  exp_t        exp_q[$];
  string       tag_q[$];
  logic [31:0] model_ir;

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_vec_t sample();
    ctrl_vec_t v;
    v.pc_ld   = ctrl_if.pc_ld;
    v.pc_inc  = ctrl_if.pc_inc;
    v.pc_sel  = ctrl_if.pc_sel;
    v.ir_ld   = ctrl_if.ir_ld;
    v.im_cs   = ctrl_if.im_cs;
    v.im_rd   = ctrl_if.im_rd;
    v.dm_cs   = ctrl_if.dm_cs;
    v.dm_rd   = ctrl_if.dm_rd;
    v.dm_wr   = ctrl_if.dm_wr;
    v.s_addr  = ctrl_if.S_Addr;
    v.t_addr  = ctrl_if.T_Addr;
    v.d_addr  = ctrl_if.D_Addr;
    v.d_en    = ctrl_if.D_En;
    v.fs      = ctrl_if.FS;
    v.t_sel   = ctrl_if.T_Sel;
    v.hilo_ld = ctrl_if.HILO_ld;
    v.y_sel   = ctrl_if.Y_Sel;
    v.halt    = ctrl_if.halt;
    return v;
  endfunction

  // All-quiet control word for a given IR: only the register read addresses.
  function automatic ctrl_vec_t idle(input logic [31:0] ir);
    ctrl_vec_t v;
    v        = '0;
    v.s_addr = ir[25:21];
    v.t_addr = ir[20:16];
    return v;
  endfunction

  task automatic push(input string tag, input ctrl_vec_t v, input bit load,
                      input logic [31:0] nir, input logic nz);
    exp_t e;
    e.vec  = v;
    e.load = load;
    e.nir  = nir;
    e.nz   = nz;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_reset(input string tag);
    ctrl_vec_t v = idle(model_ir);
    v.pc_ld  = 1'b1;
    v.pc_sel = 2'd3;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  // FETCH still shows the previous IR; the new word is loaded at its end.
  task automatic push_fetch(input string tag, input logic [31:0] ir, input logic z);
    ctrl_vec_t v = idle(model_ir);
    v.im_cs  = 1'b1;
    v.im_rd  = 1'b1;
    v.ir_ld  = 1'b1;
    v.pc_inc = 1'b1;
    push(tag, v, 1'b1, ir, z);
    model_ir = ir;
  endtask

  task automatic push_decode(input string tag, input logic pc_ld, input logic [1:0] pc_sel);
    ctrl_vec_t v = idle(model_ir);
    v.pc_ld  = pc_ld;
    v.pc_sel = pc_sel;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  task automatic push_exec(input string tag, input logic [4:0] fs, input logic t_sel,
                           input logic hilo);
    ctrl_vec_t v = idle(model_ir);
    v.fs      = fs;
    v.t_sel   = t_sel;
    v.hilo_ld = hilo;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  task automatic push_mem(input string tag, input logic rd, input logic wr);
    ctrl_vec_t v = idle(model_ir);
    v.dm_cs = 1'b1;
    v.dm_rd = rd;
    v.dm_wr = wr;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  task automatic push_wb(input string tag, input logic [4:0] d_addr, input logic [2:0] y_sel,
                         input logic [4:0] fs);
    ctrl_vec_t v = idle(model_ir);
    v.d_en   = 1'b1;
    v.d_addr = d_addr;
    v.y_sel  = y_sel;
    v.fs     = fs;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  task automatic push_br(input string tag, input logic taken);
    ctrl_vec_t v = idle(model_ir);
    v.pc_ld = taken;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  task automatic push_halt(input string tag);
    ctrl_vec_t v = idle(model_ir);
    v.halt = 1'b1;
    push(tag, v, 1'b0, '0, 1'b0);
  endtask

  // Consumes exactly one expected entry per clock, so it always terminates.
  task automatic run();
    exp_t  e;
    string t;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, sample(), e.vec);
      if (e.load) begin
        ctrl_if.IR = e.nir;
        ctrl_if.Z  = e.nz;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    ctrl_if.IR = 32'h0;
    ctrl_if.C  = 1'b0;
    ctrl_if.V  = 1'b0;
    ctrl_if.N  = 1'b0;
    ctrl_if.Z  = 1'b0;
    model_ir   = 32'h0;

    repeat (3) @(posedge clk);
    push_reset("in_reset");
    run();
    @(posedge clk);
    #1 reset = 1'b0;
    push_reset("reset_state");

    // add $9,$10,$11
    push_fetch("add_fetch", 32'h014B4820, 1'b0);
    push_decode("add_decode", 1'b0, 2'd0);
    push_exec("add_exec", 5'h02, 1'b0, 1'b0);
    push_wb("add_wb", 5'd9, 3'd2, 5'h02);

    // lw $8,4($9)
    push_fetch("lw_fetch", 32'h8D280004, 1'b0);
    push_decode("lw_decode", 1'b0, 2'd0);
    push_exec("lw_exec", 5'h02, 1'b1, 1'b0);
    push_mem("lw_mem", 1'b1, 1'b0);
    push_wb("lw_wb", 5'd8, 3'd1, 5'h02);

    // beq taken (Z=1) and not taken (Z=0)
    push_fetch("beq1_fetch", 32'h11090003, 1'b1);
    push_decode("beq1_decode", 1'b0, 2'd0);
    push_exec("beq1_exec", 5'h04, 1'b0, 1'b0);
    push_br("beq1_br", 1'b1);
    push_fetch("beq0_fetch", 32'h11090003, 1'b0);
    push_decode("beq0_decode", 1'b0, 2'd0);
    push_exec("beq0_exec", 5'h04, 1'b0, 1'b0);
    push_br("beq0_br", 1'b0);

    // bne with Z=0 is taken
    push_fetch("bne_fetch", 32'h15090003, 1'b0);
    push_decode("bne_decode", 1'b0, 2'd0);
    push_exec("bne_exec", 5'h04, 1'b0, 1'b0);
    push_br("bne_br", 1'b1);

    // mult $9,$10 retires from EXEC
    push_fetch("mult_fetch", 32'h012A0018, 1'b0);
    push_decode("mult_decode", 1'b0, 2'd0);
    push_exec("mult_exec", 5'h1E, 1'b0, 1'b1);

    // mflo $12 / mfhi $13
    push_fetch("mflo_fetch", 32'h00006012, 1'b0);
    push_decode("mflo_decode", 1'b0, 2'd0);
    push_exec("mflo_exec", 5'h00, 1'b0, 1'b0);
    push_wb("mflo_wb", 5'd12, 3'd3, 5'h00);
    push_fetch("mfhi_fetch", 32'h00006810, 1'b0);
    push_decode("mfhi_decode", 1'b0, 2'd0);
    push_exec("mfhi_exec", 5'h00, 1'b0, 1'b0);
    push_wb("mfhi_wb", 5'd13, 3'd4, 5'h00);

    // addi $8,$9,-1 and lui $10,0x1234
    push_fetch("addi_fetch", 32'h2128FFFF, 1'b0);
    push_decode("addi_decode", 1'b0, 2'd0);
    push_exec("addi_exec", 5'h02, 1'b1, 1'b0);
    push_wb("addi_wb", 5'd8, 3'd2, 5'h02);
    push_fetch("lui_fetch", 32'h3C0A1234, 1'b0);
    push_decode("lui_decode", 1'b0, 2'd0);
    push_exec("lui_exec", 5'h0D, 1'b1, 1'b0);
    push_wb("lui_wb", 5'd10, 3'd2, 5'h0D);

    // j and jr retire from DECODE
    push_fetch("j_fetch", 32'h08000010, 1'b0);
    push_decode("j_decode", 1'b1, 2'd1);
    push_fetch("jr_fetch", 32'h03E00008, 1'b0);
    push_decode("jr_decode", 1'b1, 2'd2);

    // sw $8,4($9) completes normally
    push_fetch("sw_fetch", 32'hAD280004, 1'b0);
    push_decode("sw_decode", 1'b0, 2'd0);
    push_exec("sw_exec", 5'h02, 1'b1, 1'b0);
    push_mem("sw_mem", 1'b0, 1'b1);

    // second sw: reset arrives as MEM is entered
    push_fetch("sw2_fetch", 32'hAD280004, 1'b0);
    push_decode("sw2_decode", 1'b0, 2'd0);
    push_exec("sw2_exec", 5'h02, 1'b1, 1'b0);
    run();
    @(posedge clk);
    #1 reset = 1'b1;
    push_reset("sw2_mem_reset");
    run();
    @(posedge clk);
    #1 reset = 1'b0;
    push_reset("reset_again");

    // illegal opcode -> HALT, held
    push_fetch("ill_fetch", 32'hFC000000, 1'b0);
    push_decode("ill_decode", 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) push_halt($sformatf("halt_%0d", i));
    run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
